// File: rtl/core0_pkg.sv
// Shared encodings for the core0 multicycle control path: opcodes, ALU codes,
// datapath select values, FSM states and the per-state control bundle.
package core0_pkg;

   localparam int unsigned OP_W   = 7;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned ALUC_W = 3;
   localparam int unsigned SEL_W  = 2;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;

   localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWRITE = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   // Moore control bundle decoded from the current state
   typedef struct packed {
      logic             pc_update;
      logic             branch;
      logic             adr_src;
      logic             ir_write;
      logic             mem_write;
      logic             reg_write;
      logic [SEL_W-1:0] result_src;
      logic [SEL_W-1:0] alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      aluop_t           aluop;
   } ctrl_t;

   // funct3 values the ALU path implements: add/sub, or, and
   function automatic logic funct3_supported(input logic [F3_W-1:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/core0_alu_decoder.sv
// Combinational ALU control decode from the FSM's aluop plus instruction
// funct fields.
module core0_alu_decoder
   import core0_pkg::*;
(
   input  aluop_t              i_aluop,
   input  logic [F3_W-1:0]     i_funct3,
   input  logic                i_op5,
   input  logic                i_funct7b5,
   output logic [ALUC_W-1:0]   o_alu_ctrl_c
);

   always_comb begin
      o_alu_ctrl_c = ALU_ADD;
      case (i_aluop)
         ALUOP_SUB:   o_alu_ctrl_c = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // funct7b5 only means sub for register-register forms
               3'b000:  o_alu_ctrl_c = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b110:  o_alu_ctrl_c = ALU_OR;
               3'b111:  o_alu_ctrl_c = ALU_AND;
               default: o_alu_ctrl_c = ALU_ADD;
            endcase
         end
         default:     o_alu_ctrl_c = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/core0_main_fsm.sv
// Multicycle control FSM for core0: sequences lw/sw/R/I/beq/jal and drives
// every datapath select/enable. Define CORE0_FSM_TRAP_EN for a sticky TRAP state.
module core0_main_fsm
   import core0_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     op,
   input  logic [F3_W-1:0]     funct3,
   input  logic                funct7b5,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                adr_src,
   output logic                ir_write,
   output logic                mem_write,
   output logic                reg_write,
   output logic [SEL_W-1:0]    result_src,
   output logic [SEL_W-1:0]    alu_src_a,
   output logic [SEL_W-1:0]    alu_src_b,
`ifdef CORE0_FSM_TRAP_EN
   output logic                illegal_instr,
`endif
   output logic [ALUC_W-1:0]   alu_ctrl
);

   state_t              r_state;
   state_t              w_next;
   ctrl_t               w_ctrl;
   logic [ALUC_W-1:0]   w_alu_ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_ctrl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.ir_write   = mem_ready;
            w_ctrl.pc_update  = mem_ready;
            w_ctrl.alu_src_a  = SRCA_PC;
            w_ctrl.alu_src_b  = SRCB_FOUR;
            w_ctrl.result_src = RES_ALU;
            w_ctrl.aluop      = ALUOP_ADD;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            // branch target precomputed from OldPC + imm
            w_ctrl.alu_src_a = SRCA_OLDPC;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.aluop     = ALUOP_ADD;
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECR;
               OP_I:         w_next = S_EXECI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
`ifdef CORE0_FSM_TRAP_EN
               default:      w_next = S_TRAP;
`else
               default:      w_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.aluop     = ALUOP_ADD;
            w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            w_ctrl.adr_src    = 1'b1;
            w_ctrl.result_src = RES_ALUOUT;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWRITE: begin
            w_ctrl.adr_src   = 1'b1;
            w_ctrl.mem_write = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_MEMWB: begin
            w_ctrl.result_src = RES_DATA;
            w_ctrl.reg_write  = 1'b1;
            w_next = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = (r_state == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
            w_ctrl.aluop     = ALUOP_FUNCT;
`ifdef CORE0_FSM_TRAP_EN
            w_next = funct3_supported(funct3) ? S_ALUWB : S_TRAP;
`else
            w_next = S_ALUWB;
`endif
         end
         S_ALUWB: begin
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.reg_write  = 1'b1;
            w_next = S_FETCH;
         end
         S_BEQ: begin
            w_ctrl.alu_src_a  = SRCA_RS1;
            w_ctrl.alu_src_b  = SRCB_RS2;
            w_ctrl.aluop      = ALUOP_SUB;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.branch     = 1'b1;
            w_next = S_FETCH;
         end
         S_JAL: begin
            w_ctrl.alu_src_a  = SRCA_OLDPC;
            w_ctrl.alu_src_b  = SRCB_FOUR;
            w_ctrl.aluop      = ALUOP_ADD;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.pc_update  = 1'b1;
            w_next = S_ALUWB;
         end
         // only reachable with the trap build; exits solely through reset
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
   end

   core0_alu_decoder u_alu_dec (
      .i_aluop      (w_ctrl.aluop),
      .i_funct3     (funct3),
      .i_op5        (op[5]),
      .i_funct7b5   (funct7b5),
      .o_alu_ctrl_c (w_alu_ctrl)
   );

   // state already sits at FETCH during reset; only the enables need masking
   assign pc_write   = rst_n & (w_ctrl.pc_update | (w_ctrl.branch & zero));
   assign ir_write   = rst_n & w_ctrl.ir_write;
   assign mem_write  = rst_n & w_ctrl.mem_write;
   assign reg_write  = rst_n & w_ctrl.reg_write;
   assign adr_src    = w_ctrl.adr_src;
   assign result_src = w_ctrl.result_src;
   assign alu_src_a  = w_ctrl.alu_src_a;
   assign alu_src_b  = w_ctrl.alu_src_b;
   assign alu_ctrl   = w_alu_ctrl;

`ifdef CORE0_FSM_TRAP_EN
   assign illegal_instr = (r_state == S_TRAP);
`endif

endmodule
